sort_seq_det: RTL and testbench



---
 rtl/sort_det_pkg.sv | 28 ++
 rtl/ser_sym_deser.sv | 46 ++++
 rtl/sort_seq_det.sv | 153 +++++++++++++++
 tb/tb_sort_seq_det.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_det_pkg.sv
// Shared types for the sorted-sequence detector: mode encodings, FSM states
// and the adjacent-symbol ordering test.
package sort_det_pkg;

    localparam logic [1:0] MODE_ASC  = 2'b00;
    localparam logic [1:0] MODE_NDEC = 2'b01;
    localparam logic [1:0] MODE_DESC = 2'b10;
    localparam logic [1:0] MODE_NINC = 2'b11;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_REST  = 1'b1
    } state_t;

    // a is the earlier symbol, b the newer one; callers zero-extend to 32 bits.
    function automatic logic sort_ok(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] mode);
        logic ok;
        case (mode)
            MODE_ASC:  ok = (b > a);
            MODE_NDEC: ok = (b >= a);
            MODE_DESC: ok = (b < a);
            default:   ok = (b <= a);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ser_sym_deser.sv
// MSB-first deserialiser: shifts valid bits in and flags the bit that completes
// each SYM_W-bit symbol; sym is valid combinationally alongside sym_done.
module ser_sym_deser #(
    parameter int SYM_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             in_valid,
    output logic [SYM_W-1:0] sym,
    output logic             sym_done
);

    localparam int             BCW      = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(SYM_W - 1);

    logic [BCW-1:0] bit_cnt;

    assign sym_done = in_valid && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (in_valid) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
        end
    end

    // Only the SYM_W-1 older bits need storage; the newest bit is ser_in itself.
    if (SYM_W > 1) begin : g_sr
        logic [SYM_W-2:0] sym_sr;

        assign sym = {sym_sr, ser_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                sym_sr <= '0;
            end else if (in_valid) begin
                sym_sr <= sym[SYM_W-2:0];
            end
        end
    end else begin : g_nosr
        assign sym = ser_in;
    end

endmodule

// File: rtl/sort_seq_det.sv
// Sorted-sequence detector: flags NSYM-symbol frames ordered per mode.
// Define SORT_DET_OVERLAP_EN for sliding-window detection over the last NSYM symbols.
module sort_seq_det
    import sort_det_pkg::*;
#(
    parameter int SYM_W = 2,
    parameter int NSYM  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    output logic             det,
    output logic             frame_done,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    output state_t           dbg_state
);

    localparam int            CW       = (NSYM > 2) ? $clog2(NSYM) : 1;
    localparam logic [CW-1:0] LAST_SYM = CW'(NSYM - 1);

    logic [SYM_W-1:0] sym;
    logic             sym_done;
    state_t           state, state_nxt;
    logic [SYM_W-1:0] prev;
    logic [1:0]       mode_q;
    logic [CW-1:0]    sym_cnt;
    logic             pass;
    logic             det_nxt, frame_done_nxt;

    ser_sym_deser #(.SYM_W(SYM_W)) u_deser (
        .clk      (clk),
        .rst      (rst),
        .ser_in   (ser_in),
        .in_valid (in_valid),
        .sym      (sym),
        .sym_done (sym_done)
    );

    assign pass      = sort_ok(32'(prev), 32'(sym), mode_q);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FIRST;
        else     state <= state_nxt;
    end

`ifdef SORT_DET_OVERLAP_EN
    logic [CW-1:0] run, run_upd;

    // A mode switch restarts the run; otherwise extend (saturating) or drop it.
    always_comb begin
        run_upd = '0;
        if (mode == mode_q && pass)
            run_upd = (run == LAST_SYM) ? run : run + CW'(1);
    end

    always_comb begin
        state_nxt = state;
        if (state == S_FIRST && sym_done) state_nxt = S_REST;
    end

    always_comb begin
        det_nxt        = 1'b0;
        frame_done_nxt = 1'b0;
        if (state == S_REST && sym_done) begin
            det_nxt        = (run_upd == LAST_SYM);
            frame_done_nxt = (sym_cnt == LAST_SYM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            mode_q  <= '0;
            sym_cnt <= '0;
            run     <= '0;
        end else if (sym_done) begin
            prev   <= sym;
            mode_q <= mode;
            if (state == S_FIRST) begin
                sym_cnt <= CW'(1);
                run     <= '0;
            end else begin
                if (sym_cnt != LAST_SYM) sym_cnt <= sym_cnt + CW'(1);
                run <= run_upd;
            end
        end
    end
`else
    logic sorted;
    logic last_sym;

    assign last_sym = (state == S_REST) && sym_done && (sym_cnt == LAST_SYM);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FIRST: if (sym_done) state_nxt = S_REST;
            S_REST:  if (last_sym) state_nxt = S_FIRST;
            default: state_nxt = S_FIRST;
        endcase
    end

    always_comb begin
        det_nxt        = 1'b0;
        frame_done_nxt = 1'b0;
        if (last_sym) begin
            frame_done_nxt = 1'b1;
            det_nxt        = sorted && pass;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            mode_q  <= '0;
            sym_cnt <= '0;
            sorted  <= 1'b0;
        end else if (sym_done) begin
            prev <= sym;
            if (state == S_FIRST) begin
                mode_q  <= mode;
                sym_cnt <= CW'(1);
                sorted  <= 1'b1;
            end else if (last_sym) begin
                sym_cnt <= '0;
                sorted  <= 1'b0;
            end else begin
                sym_cnt <= sym_cnt + CW'(1);
                sorted  <= sorted && pass;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            det        <= 1'b0;
            frame_done <= 1'b0;
            sym_valid  <= 1'b0;
            sym_out    <= '0;
        end else begin
            det        <= det_nxt;
            frame_done <= frame_done_nxt;
            sym_valid  <= sym_done;
            if (sym_done) sym_out <= sym;
        end
    end

endmodule

// File: tb/tb_sort_seq_det.sv
// Bench for sort_seq_det: a 2x2 and a 3x4 instance checked every cycle against
// a symbol-history reference model (window or frame view, per SORT_DET_OVERLAP_EN).
module tb_sort_seq_det;
  import sort_det_pkg::*;

  logic clk;
  logic rst0, ser0, val0;
  logic [1:0] mode0;
  logic det0, fd0, sv0;
  logic [1:0] so0;
  state_t st0;
  logic rst1, ser1, val1;
  logic [1:0] mode1;
  logic det1, fd1, sv1;
  logic [2:0] so1;
  state_t st1;

  int n_vec = 0;
  int n_err = 0;

  // reference model state, index 0 = 2x2 instance, 1 = 3x4 instance
  int sw[2] = '{2, 3};
  int ns[2] = '{2, 4};
  bit bq[2][$];
  int hist_s[2][$];
  int hist_m[2][$];
  int total[2];
  bit e_det[2], e_fd[2], e_sv[2];
  int e_so[2];

  sort_seq_det #(.SYM_W(2), .NSYM(2)) dut0 (
    .clk(clk), .rst(rst0), .ser_in(ser0), .in_valid(val0), .mode(mode0),
    .det(det0), .frame_done(fd0), .sym_out(so0), .sym_valid(sv0), .dbg_state(st0)
  );

  sort_seq_det #(.SYM_W(3), .NSYM(4)) dut1 (
    .clk(clk), .rst(rst1), .ser_in(ser1), .in_valid(val1), .mode(mode1),
    .det(det1), .frame_done(fd1), .sym_out(so1), .sym_valid(sv1), .dbg_state(st1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst0 = 1'b1; ser0 = 1'b0; val0 = 1'b0; mode0 = 2'd0;
    rst1 = 1'b1; ser1 = 1'b0; val1 = 1'b0; mode1 = 2'd0;
  end

  // reference model
  function automatic bit pass_ok(int a, int b, int m);
    case (m)
      0: return b > a;
      1: return b >= a;
      2: return b < a;
      default: return b <= a;
    endcase
  endfunction

  function automatic bit window_sorted(int k, bit same_mode);
    bit ok = 1'b1;
    int m0 = hist_m[k][0];
    for (int i = 1; i < hist_s[k].size(); i++) begin
      if (same_mode && hist_m[k][i] != m0) ok = 1'b0;
      if (!pass_ok(hist_s[k][i-1], hist_s[k][i], m0)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic model_update(input int k, input bit r, input bit v, input bit b,
                              input logic [1:0] m);
    int s;
    e_det[k] = 1'b0; e_fd[k] = 1'b0; e_sv[k] = 1'b0;
    if (r) begin
      bq[k].delete(); hist_s[k].delete(); hist_m[k].delete();
      total[k] = 0; e_so[k] = 0;
    end else if (v) begin
      bq[k].push_back(b);
      if (bq[k].size() == sw[k]) begin
        s = 0;
        foreach (bq[k][i]) s = s * 2 + int'(bq[k][i]);
        bq[k].delete();
        e_sv[k] = 1'b1;
        e_so[k] = s;
        hist_s[k].push_back(s);
        hist_m[k].push_back(int'(m));
        if (total[k] < ns[k]) total[k]++;
`ifdef SORT_DET_OVERLAP_EN
        if (hist_s[k].size() > ns[k]) begin
          void'(hist_s[k].pop_front());
          void'(hist_m[k].pop_front());
        end
        e_fd[k] = (total[k] >= ns[k]);
        if (hist_s[k].size() == ns[k]) e_det[k] = window_sorted(k, 1'b1);
`else
        if (hist_s[k].size() == ns[k]) begin
          e_fd[k] = 1'b1;
          e_det[k] = window_sorted(k, 1'b0);
          hist_s[k].delete();
          hist_m[k].delete();
        end
`endif
      end
    end
  endtask

  // driver: one clock cycle on instance k, returns observed and expected outputs
  task automatic step(input int k, input bit r, input bit v, input bit b,
                      input logic [1:0] m, output logic [5:0] obs, output logic [5:0] exp_v);
    if (k == 0) begin
      rst0 = r; val0 = v; ser0 = b; mode0 = m; rst1 = 1'b0; val1 = 1'b0;
    end else begin
      rst1 = r; val1 = v; ser1 = b; mode1 = m; rst0 = 1'b0; val0 = 1'b0;
    end
    @(posedge clk);
    model_update(k, r, v, b, m);
    #1;
    if (k == 0) obs = {det0, fd0, sv0, 1'b0, so0};
    else        obs = {det1, fd1, sv1, so1};
    exp_v = {e_det[k], e_fd[k], e_sv[k], 3'(e_so[k])};
  endtask

  task automatic test_reset;
    logic [5:0] o, e;
    for (int k = 0; k < 2; k++) begin
      step(k, 1'b1, 1'b1, 1'b1, 2'd0, o, e);
      step(k, 1'b1, 1'b0, 1'b0, 2'd0, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset inst=%0d got=%b exp=%b", k, o, e);
      end
    end
    n_vec++;
    if (st0 !== S_FIRST || st1 !== S_FIRST) begin
      n_err++;
      $display("FAIL reset_state got=%0d/%0d exp=%0d", st0, st1, S_FIRST);
    end
  endtask

  task automatic test_pairs;
    logic [5:0] o, e;
    logic [3:0] pat[6] = '{4'b1011, 4'b1110, 4'b0101, 4'b0101, 4'b1100, 4'b0011};
    logic [1:0] md[6]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int f = 0; f < 6; f++) begin
      for (int j = 3; j >= 0; j--) begin
        step(0, 1'b0, 1'b1, pat[f][j], md[f], o, e);
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL pairs frame=%0d bit=%0d got=%b exp=%b", f, 3 - j, o, e);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [5:0] o, e;
    bit bits[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit vals[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      step(0, 1'b0, vals[i], bits[i], 2'd0, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall cyc=%0d got=%b exp=%b", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [5:0] o, e;
    bit bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(0, (i == 3), 1'b1, bits[i], 2'd0, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, o, e);
      end
    end
  endtask

  task automatic test_wide;
    logic [5:0] o, e;
    int syms[5][4] = '{'{1, 3, 5, 7}, '{1, 3, 3, 7}, '{1, 3, 3, 7}, '{1, 3, 5, 7}, '{7, 5, 5, 1}};
    logic [1:0] md[5] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3};
    logic [1:0] m;
    step(1, 1'b1, 1'b0, 1'b0, 2'd0, o, e);
    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 4; s++) begin
        // frame 3 switches to non-increasing after its first symbol
        m = (f == 3 && s > 0) ? 2'd3 : md[f];
        for (int j = 2; j >= 0; j--) begin
          step(1, 1'b0, 1'b1, syms[f][s][j], m, o, e);
          n_vec++;
          if (o !== e) begin
            n_err++;
            $display("FAIL wide frame=%0d sym=%0d bit=%0d got=%b exp=%b", f, s, 2 - j, o, e);
          end
        end
      end
    end
  endtask

  task automatic test_window;
    logic [5:0] o, e;
    int syms[6] = '{0, 1, 2, 1, 2, 3};
    int n_det = 0;
    step(0, 1'b1, 1'b0, 1'b0, 2'd0, o, e);
    for (int s = 0; s < 6; s++) begin
      for (int j = 1; j >= 0; j--) begin
        step(0, 1'b0, 1'b1, syms[s][j], 2'd0, o, e);
        if (o[5]) n_det++;
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL window sym=%0d bit=%0d got=%b exp=%b", s, 1 - j, o, e);
        end
      end
    end
`ifdef SORT_DET_OVERLAP_EN
    n_vec++;
    if (n_det != 4) begin
      n_err++;
      $display("FAIL window_count got=%0d exp=4", n_det);
    end
`else
    n_vec++;
    if (n_det != 2) begin
      n_err++;
      $display("FAIL window_count got=%0d exp=2", n_det);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [5:0] o, e;
    logic [1:0] m;
    for (int f = 0; f < 60; f++) begin
      m = 2'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) begin
        step(0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), m, o, e);
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL b2b frame=%0d bit=%0d got=%b exp=%b", f, j, o, e);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [5:0] o, e;
    logic [1:0] cur_m[2] = '{2'd0, 2'd0};
    int k;
    for (int i = 0; i < 1500; i++) begin
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) cur_m[k] = 2'($urandom_range(0, 3));
      step(k, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), cur_m[k], o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random cyc=%0d inst=%0d got=%b exp=%b", i, k, o, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_pairs;
    test_stall;
    test_reset_mid;
    test_wide;
    test_window;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
